// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: opcode values, FSM state encoding, register-file write source selects.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } cpu_state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Purpose: combinational map from (state, latched opcode, latched flags) to datapath strobes.
// Latency: 0 cycles, all inputs are flops in cpu_control_unit, so outputs are Moore.
// Backpressure: none; MEMORY strobes simply persist while the FSM waits for mem_ready.
// Ports: state/op/zf/cf in; imem/decode/alu/regfile/dmem/PC strobes, halted, fault out.
module cpu_control_decode
  import cpu_pkg::*;
(
  input  cpu_state_t  state,
  input  logic [3:0]  op,
  input  logic        zf,
  input  logic        cf,
  output logic        imem_enable,
  output logic        decode_enable,
  output logic        alu_enable,
  output logic [3:0]  alu_op,
  output logic        reg_write_enable,
  output logic [1:0]  reg_write_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_increment,
  output logic        jump_enable,
  output logic        return_enable,
  output logic        halted,
  output logic        fault
);

  always_comb begin
    imem_enable      = 1'b0;
    decode_enable    = 1'b0;
    alu_enable       = 1'b0;
    alu_op           = 4'h0;
    reg_write_enable = 1'b0;
    reg_write_sel    = SEL_ALU;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    pc_increment     = 1'b0;
    jump_enable      = 1'b0;
    return_enable    = 1'b0;
    halted           = 1'b0;
    fault            = 1'b0;
    case (state)
      S_FETCH:   imem_enable = 1'b1;
      S_DECODE:  decode_enable = 1'b1;
      S_EXECUTE: begin
        // alu_op is only presented while the ALU is actually enabled.
        if (is_alu_op(op)) begin
          alu_enable = 1'b1;
          alu_op     = op;
        end
      end
      S_MEMORY: begin
        mem_read  = (op == OP_LD);
        mem_write = (op == OP_ST);
      end
      S_WRITEBACK: begin
        // Exactly one PC action per instruction is raised here.
        case (op)
          OP_LDI: begin
            reg_write_enable = 1'b1;
            reg_write_sel    = SEL_IMM;
            pc_increment     = 1'b1;
          end
          OP_LD: begin
            reg_write_enable = 1'b1;
            reg_write_sel    = SEL_MEM;
            pc_increment     = 1'b1;
          end
          OP_JMP, OP_CALL: jump_enable = 1'b1;
          OP_JZ: begin
            jump_enable  = zf;
            pc_increment = ~zf;
          end
          OP_JC: begin
            jump_enable  = cf;
            pc_increment = ~cf;
          end
          OP_RET: return_enable = 1'b1;
          default: begin
            // NOP, ST and the ALU group all advance the PC.
            reg_write_enable = is_alu_op(op);
            pc_increment     = 1'b1;
          end
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Purpose: multi-cycle sequencer FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK with call-depth tracking.
// Latency: 4 cycles per instruction, 5+w for LD/ST (w = extra cycles waiting on mem_ready).
// Backpressure: MEMORY holds its request until mem_ready, faulting after MEM_TIMEOUT cycles.
// Ports: clk, reset (async active-low), start, opcode, zero/carry flags, mem_ready in;
//        datapath strobes, halted, fault, call_depth and debug state out.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [3:0]                       opcode,
  input  logic                             zero_flag,
  input  logic                             carry_flag,
  input  logic                             mem_ready,
  output logic                             imem_enable,
  output logic                             decode_enable,
  output logic                             alu_enable,
  output logic [3:0]                       alu_op,
  output logic                             reg_write_enable,
  output logic [1:0]                       reg_write_sel,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic                             pc_increment,
  output logic                             jump_enable,
  output logic                             return_enable,
  output logic                             halted,
  output logic                             fault,
  output logic [$clog2(STACK_DEPTH+1)-1:0] call_depth,
  output logic [2:0]                       state
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  cpu_state_t     cur_state;
  logic [3:0]     op_q;
  logic           zf_q;
  logic           cf_q;
  logic [DW-1:0]  depth_q;
  logic [TW-1:0]  wait_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      op_q      <= 4'h0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      depth_q   <= '0;
      wait_q    <= '0;
    end else begin
      case (cur_state)
        S_IDLE: if (start) cur_state <= S_FETCH;
        S_FETCH: cur_state <= S_DECODE;
        S_DECODE: begin
          // Sampled on the edge into EXECUTE so EXECUTE strobes come from flops.
          op_q      <= opcode;
          cur_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          zf_q   <= zero_flag;
          cf_q   <= carry_flag;
          wait_q <= '0;
          // Stack bound violations fault before any PC or depth change.
          if ((op_q == OP_CALL && depth_q == DW'(STACK_DEPTH)) ||
              (op_q == OP_RET && depth_q == '0))
            cur_state <= S_FAULT;
          else if (op_q == OP_LD || op_q == OP_ST)
            cur_state <= S_MEMORY;
          else if (op_q == OP_HLT)
            cur_state <= S_HALT;
          else
            cur_state <= S_WRITEBACK;
        end
        S_MEMORY: begin
          // wait_q counts completed MEMORY cycles; ready on the last allowed cycle still wins.
          if (mem_ready)
            cur_state <= S_WRITEBACK;
          else if (wait_q == TW'(MEM_TIMEOUT - 1))
            cur_state <= S_FAULT;
          else
            wait_q <= wait_q + TW'(1);
        end
        S_WRITEBACK: begin
          cur_state <= S_FETCH;
          if (op_q == OP_CALL)
            depth_q <= depth_q + DW'(1);
          else if (op_q == OP_RET)
            depth_q <= depth_q - DW'(1);
        end
        default: ; // HALT and FAULT are left only through reset
      endcase
    end
  end

  assign call_depth = depth_q;
  assign state      = cur_state;

  cpu_control_decode u_decode (
    .state            (cur_state),
    .op               (op_q),
    .zf               (zf_q),
    .cf               (cf_q),
    .imem_enable      (imem_enable),
    .decode_enable    (decode_enable),
    .alu_enable       (alu_enable),
    .alu_op           (alu_op),
    .reg_write_enable (reg_write_enable),
    .reg_write_sel    (reg_write_sel),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .pc_increment     (pc_increment),
    .jump_enable      (jump_enable),
    .return_enable    (return_enable),
    .halted           (halted),
    .fault            (fault)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level model produces the expected per-cycle
// outputs, a negedge compare process checks them, plus literal latency/state checks.
module tb_cpu_control_unit;

  localparam int SD = 2;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset, start, zero_flag, carry_flag, mem_ready;
  logic [3:0] opcode;
  logic       imem_enable, decode_enable, alu_enable, reg_write_enable;
  logic       mem_read, mem_write, pc_increment, jump_enable, return_enable, halted, fault;
  logic [3:0] alu_op;
  logic [1:0] reg_write_sel;
  logic [1:0] call_depth;
  logic [2:0] state;

  cpu_control_unit #(.STACK_DEPTH(SD), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
    .imem_enable(imem_enable), .decode_enable(decode_enable), .alu_enable(alu_enable),
    .alu_op(alu_op), .reg_write_enable(reg_write_enable), .reg_write_sel(reg_write_sel),
    .mem_read(mem_read), .mem_write(mem_write), .pc_increment(pc_increment),
    .jump_enable(jump_enable), .return_enable(return_enable), .halted(halted),
    .fault(fault), .call_depth(call_depth), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] depth;
    logic       imem, dec, alu_en;
    logic [3:0] aop;
    logic       rwe;
    logic [1:0] sel;
    logic       mr, mw, pci, jmp, ret, hlt, flt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycles = 0;
  int    m_depth = 0;

  function automatic obs_t rec(input logic [2:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    r.depth = m_depth[1:0];
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t r;
    r.st = state;            r.depth = call_depth;
    r.imem = imem_enable;    r.dec = decode_enable;   r.alu_en = alu_enable;
    r.aop = alu_op;          r.rwe = reg_write_enable; r.sel = reg_write_sel;
    r.mr = mem_read;         r.mw = mem_write;        r.pci = pc_increment;
    r.jmp = jump_enable;     r.ret = return_enable;   r.hlt = halted;
    r.flt = fault;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the expected outputs for the current cycle, then move to the next cycle.
  task automatic step(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cycles++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = observe();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: dut state=%0d vec=%06h, model state=%0d vec=%06h",
                 t, a.st, a, e.st, e);
      end
    end
  end

  // Holds reset for two cycles, releases it, then pulses start; leaves the DUT in FETCH.
  task automatic restart();
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; m_depth = 0;
    step(rec(3'd0), "reset_hold");
    step(rec(3'd0), "reset_hold");
    reset = 1'b1;
    step(rec(3'd0), "idle");
    start = 1'b1;
    step(rec(3'd0), "idle_start");
    start = 1'b0;
  endtask

  // FETCH, DECODE, EXECUTE. Flags are valid only during EXECUTE and inverted elsewhere.
  task automatic front(input logic [3:0] op, input logic zf, input logic cf, input string tag);
    obs_t e;
    opcode = op; zero_flag = ~zf; carry_flag = ~cf; mem_ready = 1'b0;
    e = rec(3'd1); e.imem = 1'b1;
    step(e, {tag, ".fetch"});
    e = rec(3'd2); e.dec = 1'b1;
    step(e, {tag, ".decode"});
    zero_flag = zf; carry_flag = cf;
    e = rec(3'd3);
    if (op >= 4'd1 && op <= 4'd6) begin
      e.alu_en = 1'b1;
      e.aop = op;
    end
    step(e, {tag, ".execute"});
    zero_flag = ~zf; carry_flag = ~cf;
  endtask

  // rdy: number of extra MEMORY cycles before mem_ready; negative means never ready.
  task automatic run_instr(input logic [3:0] op, input logic zf, input logic cf,
                           input int rdy, input string tag, output int ncyc);
    obs_t e;
    int   c0;
    c0 = cycles;
    front(op, zf, cf, tag);
    if ((op == 4'hD && m_depth == SD) || (op == 4'hE && m_depth == 0) || op == 4'hF) begin
      ncyc = cycles - c0;
      return;
    end
    if (op == 4'h8 || op == 4'h9) begin
      for (int i = 0; i < ((rdy < 0) ? TO : rdy + 1); i++) begin
        mem_ready = (rdy >= 0) && (i == rdy);
        e = rec(3'd4); e.mr = (op == 4'h8); e.mw = (op == 4'h9);
        step(e, {tag, ".memory"});
      end
      mem_ready = 1'b0;
      if (rdy < 0) begin
        ncyc = cycles - c0;
        return;
      end
    end
    e = rec(3'd5);
    case (op)
      4'h7: begin e.rwe = 1'b1; e.sel = 2'b01; e.pci = 1'b1; end
      4'h8: begin e.rwe = 1'b1; e.sel = 2'b10; e.pci = 1'b1; end
      4'hA, 4'hD: e.jmp = 1'b1;
      4'hB: begin e.jmp = zf; e.pci = ~zf; end
      4'hC: begin e.jmp = cf; e.pci = ~cf; end
      4'hE: e.ret = 1'b1;
      default: begin e.rwe = (op >= 4'd1 && op <= 4'd6); e.pci = 1'b1; end
    endcase
    step(e, {tag, ".writeback"});
    if (op == 4'hD) m_depth++;
    else if (op == 4'hE) m_depth--;
    ncyc = cycles - c0;
  endtask

  // Terminal states: start is toggled throughout and must be ignored.
  task automatic hold(input logic [2:0] st, input int n, input string tag);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      start = i[0];
      e = rec(st);
      e.hlt = (st == 3'd6);
      e.flt = (st == 3'd7);
      step(e, tag);
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n;
    obs_t e;
    reset = 1'b1; start = 1'b0; opcode = 4'h0;
    zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("por_state", state, 0);
    chk("por_outputs", observe(), rec(3'd0));
    @(posedge clk); #1;

    restart();
    chk("start_enters_fetch", state, 1);
    run_instr(4'h1, 1'b1, 1'b0, 0, "add", n);      chk("add_latency", n, 4);
    run_instr(4'hB, 1'b1, 1'b0, 0, "jz_taken", n);
    run_instr(4'hB, 1'b0, 1'b1, 0, "jz_not_taken", n);
    run_instr(4'hC, 1'b0, 1'b1, 0, "jc_taken", n);
    run_instr(4'hC, 1'b1, 1'b0, 0, "jc_not_taken", n);
    run_instr(4'h7, 1'b0, 1'b0, 0, "ldi", n);
    run_instr(4'h2, 1'b0, 1'b1, 0, "sub", n);
    run_instr(4'h6, 1'b1, 1'b1, 0, "alu6", n);
    run_instr(4'h0, 1'b0, 1'b0, 0, "nop", n);
    run_instr(4'h9, 1'b0, 1'b0, 0, "st_fast", n);  chk("st_latency", n, 5);
    run_instr(4'hA, 1'b0, 1'b0, 0, "jmp", n);
    run_instr(4'h8, 1'b0, 1'b0, 3, "ld_wait3", n); chk("ld_wait3_latency", n, 8);
    run_instr(4'hD, 1'b0, 1'b0, 0, "call_a", n);   chk("call_a_depth", call_depth, 1);
    run_instr(4'hE, 1'b0, 1'b0, 0, "ret_a", n);    chk("ret_a_depth", call_depth, 0);
    run_instr(4'hD, 1'b0, 1'b0, 0, "call1", n);    chk("call1_depth", call_depth, 1);
    run_instr(4'hD, 1'b0, 1'b0, 0, "call2", n);    chk("call2_depth", call_depth, 2);
    run_instr(4'hD, 1'b0, 1'b0, 0, "call3", n);
    chk("call_overflow_state", state, 7);
    chk("call_overflow_depth", call_depth, 2);
    hold(3'd7, 5, "call_fault_hold");

    restart();
    run_instr(4'hE, 1'b0, 1'b0, 0, "ret_at_0", n);
    chk("ret_underflow_state", state, 7);
    hold(3'd7, 3, "ret_fault_hold");

    restart();
    run_instr(4'h8, 1'b0, 1'b0, -1, "ld_timeout", n);
    chk("ld_timeout_cycles", n, 18);
    chk("ld_timeout_fault", fault, 1);
    hold(3'd7, 3, "timeout_fault_hold");

    // Asynchronous reset during a stalled store, with a nonzero call depth.
    restart();
    run_instr(4'hD, 1'b0, 1'b0, 0, "call_pre", n);
    front(4'h9, 1'b0, 1'b0, "st_abort");
    e = rec(3'd4); e.mw = 1'b1;
    step(e, "st_abort.memory");
    chk("st_abort_mem_write_active", mem_write, 1);
    #1 reset = 1'b0;
    #1;
    chk("st_abort_mem_write_async", mem_write, 0);
    chk("st_abort_state_async", state, 0);
    chk("st_abort_depth_async", call_depth, 0);
    restart();

    run_instr(4'hF, 1'b0, 1'b0, 0, "hlt", n);
    chk("hlt_latency", n, 3);
    chk("hlt_halted", halted, 1);
    hold(3'd6, 20, "halt_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
